booth_r4_seq_ctrl: RTL and testbench
====================================

BOOTH_R4_SEQ_CTRL -- requirements
Module: booth_r4_seq_ctrl

Interface
REQ-001 SHALL have parameter NGRP, default 17, number of radix-4 groups processed per operation (fixed for 32-bit operands).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand request.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port mulcand  input  32  multiplicand, sampled on accept.
REQ-007 SHALL have port mulplier  input  32  multiplier, sampled on accept.
REQ-008 SHALL have port sign  input  1  1=signed operands, 0=unsigned, sampled on accept.
REQ-009 SHALL have port abort  input  1  cancel the operation in progress.
REQ-010 SHALL have port ppg_mulcand  output  32  registered multiplicand driven to the external partial-product generator.
REQ-011 SHALL have port ppg_r4input  output  3  current Booth window driven to the generator.
REQ-012 SHALL have port ppg_sign  output  1  registered sign driven to the generator.
REQ-013 SHALL have port ppg_pp  input  34  generator result, combinational in the same cycle.
REQ-014 SHALL have port out_valid  output  1  product available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts product.
REQ-016 SHALL have port product  output  64  result.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 SHALL accept operands on a clock edge where state=IDLE and in_valid=1, then enter CALC with group index 0 and accumulator 0.
REQ-019 SHALL form a 35-bit window source M = {e,e,mulplier,1'b0}, where e=mulplier[31] if sign=1 else 0; group i window = M[2i+2:2i], i=0..16, driven on ppg_r4input while in CALC.
REQ-020 SHALL form each term from ppg_pp as a 34-bit signed value {x, ppg_pp[32:0]}, with x=ppg_pp[33] if sign=1 else ppg_r4input[2], sign-extended to 66 bits.
REQ-021 SHALL add (term + ppg_r4input[2]) << 2i into a 66-bit accumulator each CALC cycle, modulo 2^66.
REQ-022 SHALL spend exactly NGRP cycles in CALC, with no early termination; after group 16 SHALL enter DONE with product = accumulator[63:0].
REQ-023 SHALL produce this latency: accept edge T -> CALC during cycles T+1..T+17 -> out_valid high from cycle T+18.
REQ-024 SHALL hold product, out_valid and all state stable in DONE while out_ready=0.
REQ-025 SHALL return DONE->IDLE on an edge with out_ready=1; a new accept SHALL NOT occur on that same edge.
REQ-026 SHALL return CALC->IDLE on an edge with abort=1, discarding the result and never asserting out_valid; abort SHALL be ignored in IDLE and DONE.
REQ-027 SHALL ignore in_valid outside IDLE and SHALL leave operand registers unchanged.
REQ-028 SHALL be correct for the edge windows: 000/111 contribute 0, 011 contributes +2x, 100 contributes -2x.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, force state=IDLE, in_ready=1 in the next cycle, out_valid=0, product=0, accumulator=0, group index=0 and ppg_r4input=000, with priority over abort and all handshakes.
REQ-030 SHALL, on rst mid-CALC or in DONE, drop the pending result and not present it after reset.

Verification
REQ-031 SHALL pass: sign=1, 3 x 0xFFFFFFFB (-5), accept at T -> out_valid first at T+18, product=0xFFFFFFFFFFFFFFF1.
REQ-032 SHALL pass: sign=0, 0xFFFFFFFF x 0xFFFFFFFF -> product=0xFFFFFFFE00000001; same operands with sign=1 -> 0x0000000000000001.
REQ-033 SHALL pass: sign=1, 0x80000000 x 0x80000000 -> 0x4000000000000000; sign=0 -> the same value.
REQ-034 SHALL pass: out_ready held low 5 cycles in DONE -> product and out_valid stable, in_ready=0; out_ready high -> IDLE next cycle.
REQ-035 SHALL pass: abort at group 8 -> IDLE next cycle, out_valid never high, next op 7 x 6 (sign=0) -> 42.
REQ-036 SHALL pass: rst at group 10 -> IDLE with all outputs at reset values next cycle, and no stale out_valid.

Source files
------------

// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller.
// Walks the 17 overlapping 3-bit windows of the multiplier, one per cycle,
// hands each window to an external partial-product generator and accumulates
// the returned terms into a 66-bit sum. The 64-bit product is handed off with
// a valid/ready handshake. An operation in progress can be abandoned with abort.
module booth_r4_seq_ctrl #(
  parameter int NGRP = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] mulcand,
  input  logic [31:0] mulplier,
  input  logic        sign,
  input  logic        abort,
  output logic [31:0] ppg_mulcand,
  output logic [2:0]  ppg_r4input,
  output logic        ppg_sign,
  input  logic [33:0] ppg_pp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product
);

  localparam int GW = $clog2(NGRP + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [65:0]   acc_q, acc_d;
  logic [34:0]   mplr_q, mplr_d;      // window source {e,e,multiplier,0}
  logic [31:0]   mulcand_q, mulcand_d;
  logic          sign_q, sign_d;
  logic [63:0]   product_q, product_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [2:0]    window;
  logic          term_x;
  logic [33:0]   term34;
  logic [65:0]   addend;
  logic [65:0]   shifted;
  logic [65:0]   acc_sum;
  logic          ext_bit;

  // Current Booth window; forced to 000 outside CALC so the generator idles at zero.
  always_comb begin
    window = 3'b000;
    if (state_q == CALC) begin
      window = mplr_q[{grp_q, 1'b0} +: 3];
    end
  end

  // Turn the generator result into a signed term: the top bit is the generator's
  // own sign for signed operands, otherwise the window's negate bit. The negate
  // bit is also the +1 that completes the generator's one's-complement negation.
  always_comb begin
    term_x  = sign_q ? ppg_pp[33] : window[2];
    term34  = {term_x, ppg_pp[32:0]};
    addend  = {{32{term34[33]}}, term34} + {65'd0, window[2]};
    shifted = addend << {grp_q, 1'b0};
    acc_sum = acc_q + shifted;
  end

  // Next-state and datapath decisions for the IDLE/CALC/DONE controller.
  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    acc_d       = acc_q;
    mplr_d      = mplr_q;
    mulcand_d   = mulcand_q;
    sign_d      = sign_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    ext_bit     = sign & mulplier[31];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mulcand_d  = mulcand;
          sign_d     = sign;
          mplr_d     = {ext_bit, ext_bit, mulplier, 1'b0};
          grp_d      = '0;
          acc_d      = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
        end
      end

      CALC: begin
        if (abort) begin
          // Abandon the operation; the partial sum is discarded.
          state_d    = IDLE;
          grp_d      = '0;
          acc_d      = '0;
          in_ready_d = 1'b1;
        end else begin
          acc_d = acc_sum;
          grp_d = grp_q + GW'(1);
          if (grp_q == GW'(NGRP - 1)) begin
            state_d     = DONE;
            product_d   = acc_sum[63:0];
            out_valid_d = 1'b1;
            grp_d       = '0;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        grp_d       = '0;
        acc_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns everything to an idle, empty machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      acc_q       <= '0;
      mplr_q      <= '0;
      mulcand_q   <= '0;
      sign_q      <= 1'b0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      acc_q       <= acc_d;
      mplr_q      <= mplr_d;
      mulcand_q   <= mulcand_d;
      sign_q      <= sign_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign product     = product_q;
  assign ppg_mulcand = mulcand_q;
  assign ppg_sign    = sign_q;
  assign ppg_r4input = window;

endmodule

// File: tb/tb_booth_r4_seq_ctrl.sv
// Testbench for booth_r4_seq_ctrl: models the external partial-product
// generator, drives directed and random multiplications and checks products
// through a scoreboard queue popped by an independent output monitor.
module tb_booth_r4_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mulcand;
  logic [31:0] mulplier;
  logic        sign;
  logic        abort;
  logic [31:0] ppg_mulcand;
  logic [2:0]  ppg_r4input;
  logic        ppg_sign;
  logic [33:0] ppg_pp;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  typedef struct {
    logic [63:0] prod;
    longint      acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  booth_r4_seq_ctrl #(.NGRP(17)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mulcand    (mulcand),
    .mulplier   (mulplier),
    .sign       (sign),
    .abort      (abort),
    .ppg_mulcand(ppg_mulcand),
    .ppg_r4input(ppg_r4input),
    .ppg_sign   (ppg_sign),
    .ppg_pp     (ppg_pp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External generator: multiple of the multiplicand selected by the window,
  // negative multiples returned in one's complement.
  logic [33:0] pp_x;
  logic [33:0] pp_mag;
  always_comb begin
    pp_x   = ppg_sign ? {{2{ppg_mulcand[31]}}, ppg_mulcand} : {2'b00, ppg_mulcand};
    pp_mag = '0;
    case (ppg_r4input)
      3'b001, 3'b010, 3'b101, 3'b110: pp_mag = pp_x;
      3'b011, 3'b100:                 pp_mag = pp_x << 1;
      default:                        pp_mag = '0;
    endcase
    ppg_pp = ppg_r4input[2] ? ~pp_mag : pp_mag;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Monitor: latency check on each rising out_valid, product check on each handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid got=1 exp=0");
      end else begin
        chk("latency", 64'(cyc - sb_q[0].acc_cyc), 64'd17);
      end
    end
    if (out_valid && out_ready && sb_q.size() > 0) begin
      chk("product", product, sb_q[0].prod);
      $display("txn product=%h", product);
      void'(sb_q.pop_front());
    end
    prev_ov <= out_valid;
  end

  // Offer one operation; returns just after the accept edge (plus junk cycles).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input bit push, input int junk);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=0 exp=1");
      return;
    end
    mulcand  = a;
    mulplier = b;
    sign     = s;
    in_valid = 1'b1;
    if (push) sb_q.push_back('{prod: exp, acc_cyc: cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    chk("window0", 64'(ppg_r4input), 64'({b[1:0], 1'b0}));
    for (int j = 0; j < junk; j++) begin
      in_valid = 1'b1;
      mulcand  = $urandom;
      mulplier = $urandom;
      sign     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Drain one result, optionally with random backpressure.
  task automatic finish_op(input bit rand_bp);
    int n  = 0;
    bit hs = 1'b0;
    while (!hs && n < 500) begin
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = out_valid && out_ready;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got=0 exp=1");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [34:0] mm;
    logic [63:0] e;
    logic [31:0] edge_tab [6];
    int          n;
    bit          stale;

    edge_tab[0] = 32'h0000_0000;
    edge_tab[1] = 32'hFFFF_FFFF;
    edge_tab[2] = 32'h8000_0000;
    edge_tab[3] = 32'h7FFF_FFFF;
    edge_tab[4] = 32'h5555_5555;
    edge_tab[5] = 32'hAAAA_AAAA;

    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    mulcand = '0; mulplier = '0; sign = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product",   product, 64'd0);
    chk("rst_window",    64'(ppg_r4input), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed products
    start_op(32'd3, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 0); finish_op(1'b0);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1, 0); finish_op(1'b0);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b1, 0); finish_op(1'b0);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1, 0); finish_op(1'b0);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b1, 0); finish_op(1'b0);

    // Backpressure hold in DONE, abort ignored there
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; s = 1'b1;
    e = ref_mul(a, b, s);
    start_op(a, b, s, e, 1'b1, 5);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_reached_done", 64'(out_valid), 64'd1);
    abort = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_valid",    64'(out_valid), 64'd1);
      chk("hold_product",  product, e);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    abort = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready",  64'(in_ready), 64'd1);

    // Abort at group 8
    a = $urandom; b = $urandom;
    mm = {2'b00, b, 1'b0};
    start_op(a, b, 1'b0, 64'd0, 1'b0, 0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("window8", 64'(ppg_r4input), 64'(mm[18:16]));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready",  64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_window",    64'(ppg_r4input), 64'd0);
    start_op(32'd7, 32'd6, 1'b0, 64'd42, 1'b1, 0); finish_op(1'b0);

    // Reset at group 10
    start_op($urandom, $urandom, 1'b1, 64'd0, 1'b0, 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_in_ready",  64'(in_ready), 64'd1);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_product",   product, 64'd0);
    chk("rst_mid_window",    64'(ppg_r4input), 64'd0);
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    out_ready = 1'b0;
    chk("no_stale_valid", 64'(stale), 64'd0);

    // Abort ignored in IDLE (held through the accept edge)
    abort = 1'b1;
    start_op(32'hFFFF_FFF0, 32'd100, 1'b1, ref_mul(32'hFFFF_FFF0, 32'd100, 1'b1), 1'b1, 0);
    abort = 1'b0;
    finish_op(1'b0);

    // Random operations with edge operands, busy-time junk and backpressure
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 5)] : $urandom;
      s = 1'($urandom_range(0, 1));
      start_op(a, b, s, ref_mul(a, b, s), 1'b1, $urandom_range(0, 10));
      finish_op(1'b1);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
